alu_multicycle: RTL and testbench

Parametrised, registered successor to the datapath ALU. It keeps the single-cycle logical and add/sub operations and adds logical shifts plus iterative unsigned multiply and divide. Operations use a start/busy/done handshake, and results and flags are registered. It sits in the execute stage; the control unit stalls while busy=1.

---
 rtl/alu_multicycle.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered execute-stage ALU with single-cycle logic/add/sub/shift and iterative unsigned MUL/UDIV.
// Latency: 1 cycle (done the cycle after acceptance) for single-cycle ops; N+1 cycles for MUL/UDIV, busy high for N of them.
// Backpressure: nothing is queued; start is taken only in IDLE (including the done cycle), a start while busy is dropped.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset (aborts any operation in flight, clears outputs)
//   start           request, sampled with a, b, ALUControl when the block is idle
//   a, b            N-bit operands; b[SHW-1:0] is the shift amount for LSL/LSR
//   ALUControl      4-bit operation select
//   busy            iterative operation in progress
//   done            one-cycle pulse: result and flags were loaded on the preceding edge
//   result          registered N-bit result
//   zero, negative  registered result==0 and result[N-1]
//   Carry           registered carry / borrow / nonzero high half of the product
//   overflow        registered signed overflow, or divide-by-zero for UDIV
module alu_multicycle #(
    parameter int N   = 64,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         Carry,
    output logic         overflow
);

    // Iteration counter must be able to hold N itself.
    localparam int CW = $clog2(N) + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_DIV   = 4'b1001;
    localparam logic [3:0] OP_LSL   = 4'b1010;
    localparam logic [3:0] OP_LSR   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operand registers. In MUL r_opa is the multiplicand and r_opb the
    // multiplier (shifted right each step). In DIV r_opa is the dividend,
    // which is shifted left while quotient bits enter at the bottom, and
    // r_opb is the divisor.
    logic [N-1:0]  r_opa;
    logic [N-1:0]  r_opb;

    // Product accumulator. The low half only needs N-1 bits: the bit that
    // would shift out of position 0 is never part of the final product,
    // because the product is taken from the next-state value on the last step.
    logic [N-1:0]  r_acc_hi;
    logic [N-2:0]  r_acc_lo;

    // Partial remainder for the restoring divider.
    logic [N-1:0]  r_rem;

    logic [CW-1:0] r_cnt;
    logic          r_dbz;

    logic          r_done;
    logic [N-1:0]  r_result;
    logic          r_zero;
    logic          r_neg;
    logic          r_carry;
    logic          r_ovf;

    logic          w_accept;
    logic          w_last;
    logic          w_iterative_op;

    // Single-cycle datapath
    logic [N:0]    w_add;
    logic [N:0]    w_sub;
    logic [N-1:0]  w_sc_res;
    logic          w_sc_carry;
    logic          w_sc_ovf;

    // Multiplier step
    logic [N:0]    w_mul_sum;
    logic [2*N-1:0] w_mul_prod;

    // Divider step
    logic [N:0]    w_div_shift;
    logic          w_div_ge;
    logic [N-1:0]  w_div_rem_nxt;
    logic [N-1:0]  w_div_q_nxt;

    // Result load mux
    logic          w_load;
    logic [N-1:0]  w_ld_res;
    logic          w_ld_carry;
    logic          w_ld_ovf;

    assign w_iterative_op = (ALUControl == OP_MUL) || (ALUControl == OP_DIV);
    assign w_accept       = (r_state == S_IDLE) && start;
    assign w_last         = (r_cnt == CW'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (ALUControl == OP_MUL) begin
                        w_state_nxt = S_MUL;
                    end else if (ALUControl == OP_DIV) begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle operations, computed straight from the inputs so the
    // result can load on the accepting edge.
    // ------------------------------------------------------------------
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_sc_res   = '0;
        w_sc_carry = 1'b0;
        w_sc_ovf   = 1'b0;
        case (ALUControl)
            OP_AND:   w_sc_res = a & b;
            OP_OR:    w_sc_res = a | b;
            OP_ADD: begin
                w_sc_res   = w_add[N-1:0];
                w_sc_carry = w_add[N];
                w_sc_ovf   = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
            end
            OP_SUB: begin
                // Bit N of the extended difference is the borrow (a < b unsigned).
                w_sc_res   = w_sub[N-1:0];
                w_sc_carry = w_sub[N];
                w_sc_ovf   = (a[N-1] ^ b[N-1]) & (a[N-1] ^ w_sub[N-1]);
            end
            OP_PASSB: w_sc_res = b;
            OP_NOR:   w_sc_res = ~(a | b);
            OP_LSL:   w_sc_res = a << b[SHW-1:0];
            OP_LSR:   w_sc_res = a >> b[SHW-1:0];
            default:  w_sc_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier step: add the multiplicand into the high half
    // when the current multiplier bit is set, then shift everything right.
    // ------------------------------------------------------------------
    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_opb[0] ? {1'b0, r_opa} : {(N+1){1'b0}});
    assign w_mul_prod = {w_mul_sum, r_acc_lo};

    // ------------------------------------------------------------------
    // Restoring divider step: bring down the next dividend bit, subtract
    // the divisor if it fits. With a zero divisor every step "fits", which
    // already yields an all-ones quotient.
    // ------------------------------------------------------------------
    assign w_div_shift   = {r_rem, r_opa[N-1]};
    assign w_div_ge      = (w_div_shift >= {1'b0, r_opb});
    // When the divisor fits, the difference is below the divisor and so fits in N bits.
    assign w_div_rem_nxt = w_div_ge ? N'(w_div_shift - {1'b0, r_opb}) : w_div_shift[N-1:0];
    assign w_div_q_nxt   = {r_opa[N-2:0], w_div_ge};

    // ------------------------------------------------------------------
    // Result/flag load selection
    // ------------------------------------------------------------------
    always_comb begin
        w_load     = 1'b0;
        w_ld_res   = '0;
        w_ld_carry = 1'b0;
        w_ld_ovf   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !w_iterative_op) begin
                    w_load     = 1'b1;
                    w_ld_res   = w_sc_res;
                    w_ld_carry = w_sc_carry;
                    w_ld_ovf   = w_sc_ovf;
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_load     = 1'b1;
                    w_ld_res   = w_mul_prod[N-1:0];
                    w_ld_carry = |w_mul_prod[2*N-1:N];
                end
            end
            S_DIV: begin
                if (w_last) begin
                    w_load   = 1'b1;
                    w_ld_res = r_dbz ? {N{1'b1}} : w_div_q_nxt;
                    w_ld_ovf = r_dbz;
                end
            end
            default: w_load = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_dbz    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= w_load;

            if (w_load) begin
                r_result <= w_ld_res;
                r_zero   <= (w_ld_res == '0);
                r_neg    <= w_ld_res[N-1];
                r_carry  <= w_ld_carry;
                r_ovf    <= w_ld_ovf;
            end

            if (w_accept) begin
                r_opa    <= a;
                r_opb    <= b;
                r_acc_hi <= '0;
                r_acc_lo <= '0;
                r_rem    <= '0;
                r_cnt    <= CW'(N);
                r_dbz    <= (b == '0);
            end else if (r_state == S_MUL) begin
                r_acc_hi <= w_mul_sum[N:1];
                r_acc_lo <= {w_mul_sum[0], r_acc_lo[N-2:1]};
                r_opb    <= r_opb >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end else if (r_state == S_DIV) begin
                r_rem    <= w_div_rem_nxt;
                r_opa    <= w_div_q_nxt;
                r_cnt    <= r_cnt - CW'(1);
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign zero     = r_zero;
    assign negative = r_neg;
    assign Carry    = r_carry;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors for an N=8 and an N=64 instance of alu_multicycle.
// Expected responses are queued at issue time; a per-instance monitor pops on each done pulse.
// Checks result, flags, done cycle and the number of busy cycles preceding done.
`timescale 1ns/1ps
module tb_alu_multicycle;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_DIV   = 4'b1001;
    localparam logic [3:0] OP_LSL   = 4'b1010;
    localparam logic [3:0] OP_LSR   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_UNDEF = 4'b0011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- N=8 instance ----------------
    logic        rst8, start8, busy8, done8, zero8, neg8, carry8, ovf8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8, flags8;
    assign flags8 = {zero8, neg8, carry8, ovf8};

    alu_multicycle #(.N(8)) u_dut8 (
        .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8), .ALUControl(op8),
        .busy(busy8), .done(done8), .result(res8), .zero(zero8), .negative(neg8),
        .Carry(carry8), .overflow(ovf8)
    );

    // ---------------- N=64 instance ----------------
    logic        rst64, start64, busy64, done64, zero64, neg64, carry64, ovf64;
    logic [63:0] a64, b64, res64;
    logic [3:0]  op64, flags64;
    assign flags64 = {zero64, neg64, carry64, ovf64};

    alu_multicycle #(.N(64)) u_dut64 (
        .clk(clk), .reset(rst64), .start(start64), .a(a64), .b(b64), .ALUControl(op64),
        .busy(busy64), .done(done64), .result(res64), .zero(zero64), .negative(neg64),
        .Carry(carry64), .overflow(ovf64)
    );

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flg;   // {zero, negative, Carry, overflow}
        int          cyc;   // cycle count at which done must be seen
        int          bsy;   // busy cycles immediately before done
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];
    exp_t e8, e64;
    int   run8  = 0;
    int   run64 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Called just after a falling edge; start is held for one cycle and the
    // operands are scrambled afterwards so in-flight ops must use latched values.
    task automatic issue8(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                          input logic [7:0] er, input logic [3:0] ef, input int lat, input int bz);
        exp_t e;
        e.res = {56'd0, er};
        e.flg = ef;
        e.cyc = cyc + lat;
        e.bsy = bz;
        q8.push_back(e);
        a8 = aa; b8 = bb; op8 = op; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic issue64(input logic [3:0] op, input logic [63:0] aa, input logic [63:0] bb,
                           input logic [63:0] er, input logic [3:0] ef, input int lat, input int bz);
        exp_t e;
        e.res = er;
        e.flg = ef;
        e.cyc = cyc + lat;
        e.bsy = bz;
        q64.push_back(e);
        a64 = aa; b64 = bb; op64 = op; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
    endtask

    task automatic drain8(input int lim);
        int n = 0;
        while ((q8.size() != 0 || busy8) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) begin
            total++;
            bad++;
            $display("FAIL n8_drain_timeout: %0d responses outstanding, want 0", q8.size());
            q8.delete();
        end
        @(negedge clk);
    endtask

    task automatic drain64(input int lim);
        int n = 0;
        while ((q64.size() != 0 || busy64) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) begin
            total++;
            bad++;
            $display("FAIL n64_drain_timeout: %0d responses outstanding, want 0", q64.size());
            q64.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst8) begin
            run8 = 0;
        end else begin
            if (done8) begin
                if (q8.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL n8_unexpected_done: got done=1 result=%h want no done", res8);
                end else begin
                    e8 = q8.pop_front();
                    chk("n8_result", {56'd0, res8}, e8.res);
                    chk("n8_flags", {60'd0, flags8}, {60'd0, e8.flg});
                    chk("n8_done_cycle", 64'(cyc), 64'(e8.cyc));
                    chk("n8_busy_cycles", 64'(run8), 64'(e8.bsy));
                end
            end
            if (busy8) run8++;
            else       run8 = 0;
        end
    end

    always @(negedge clk) begin
        if (rst64) begin
            run64 = 0;
        end else begin
            if (done64) begin
                if (q64.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL n64_unexpected_done: got done=1 result=%h want no done", res64);
                end else begin
                    e64 = q64.pop_front();
                    chk("n64_result", res64, e64.res);
                    chk("n64_flags", {60'd0, flags64}, {60'd0, e64.flg});
                    chk("n64_done_cycle", 64'(cyc), 64'(e64.cyc));
                    chk("n64_busy_cycles", 64'(run64), 64'(e64.bsy));
                end
            end
            if (busy64) run64++;
            else        run64 = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        rst64 = 1'b1; start64 = 1'b0; a64 = '0; b64 = '0; op64 = '0;
        repeat (3) @(negedge clk);

        chk("n8_reset_result", {56'd0, res8}, 64'd0);
        chk("n8_reset_flags", {60'd0, flags8}, 64'd0);
        chk("n8_reset_busy_done", {62'd0, busy8, done8}, 64'd0);
        chk("n64_reset_result", res64, 64'd0);
        chk("n64_reset_flags_busy_done", {58'd0, flags64, busy64, done64}, 64'd0);

        rst8 = 1'b0;
        rst64 = 1'b0;
        @(negedge clk);

        // Single-cycle ops, back to back every cycle.
        issue8(OP_ADD,   8'h7F, 8'h01, 8'h80, 4'b0101, 1, 0);
        issue8(OP_ADD,   8'hFF, 8'h01, 8'h00, 4'b1010, 1, 0);
        issue8(OP_SUB,   8'h00, 8'h01, 8'hFF, 4'b0110, 1, 0);
        issue8(OP_SUB,   8'h05, 8'h05, 8'h00, 4'b1000, 1, 0);
        issue8(OP_LSL,   8'h81, 8'h0B, 8'h08, 4'b0000, 1, 0);
        issue8(OP_LSR,   8'h80, 8'h07, 8'h01, 4'b0000, 1, 0);
        issue8(OP_PASSB, 8'h11, 8'h9C, 8'h9C, 4'b0100, 1, 0);
        issue8(OP_UNDEF, 8'h01, 8'h02, 8'h00, 4'b1000, 1, 0);
        issue8(OP_AND,   8'hC3, 8'h5A, 8'h42, 4'b0000, 1, 0);
        issue8(OP_OR,    8'hC3, 8'h5A, 8'hDB, 4'b0100, 1, 0);
        issue8(OP_NOR,   8'hC3, 8'h5A, 8'h24, 4'b0000, 1, 0);
        drain8(50);

        // MUL 0x10*0x11 = 0x110, then a single-cycle op started in the done cycle.
        issue8(OP_MUL, 8'h10, 8'h11, 8'h10, 4'b0010, 9, 8);
        repeat (8) @(negedge clk);
        issue8(OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, 0);
        drain8(50);

        // MUL 12*11 = 132
        issue8(OP_MUL, 8'd12, 8'd11, 8'h84, 4'b0100, 9, 8);
        drain8(50);

        // UDIV 200/7 = 28
        issue8(OP_DIV, 8'd200, 8'd7, 8'd28, 4'b0000, 9, 8);
        drain8(50);

        // UDIV 100/10 = 10 with a start pulse during busy that must be dropped.
        issue8(OP_DIV, 8'd100, 8'd10, 8'd10, 4'b0000, 9, 8);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; op8 = OP_AND; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain8(50);

        // UDIV by zero: all ones, overflow set, full latency.
        issue8(OP_DIV, 8'd5, 8'd0, 8'hFF, 4'b0101, 9, 8);
        drain8(50);

        // Reset during the third MUL iteration, held two cycles: op aborted, outputs cleared.
        a8 = 8'd3; b8 = 8'd5; op8 = OP_MUL; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        chk("n8_abort_result", {56'd0, res8}, 64'd0);
        chk("n8_abort_flags", {60'd0, flags8}, 64'd0);
        chk("n8_abort_busy_done", {62'd0, busy8, done8}, 64'd0);
        repeat (15) @(negedge clk);
        chk("n8_abort_idle_after", {55'd0, busy8, res8}, 64'd0);

        // N=64 MUL: 0xFFFFFFFF^2
        issue64(OP_MUL, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                64'hFFFF_FFFE_0000_0001, 4'b0100, 65, 64);
        drain64(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
